pipe_hazard_ctl: RTL
====================

# pipe_hazard_ctl

Hazard and sequencing controller for the 5-stage MIPS pipeline. It produces the write-enable, hold and flush controls for the PC and the IF/ID, ID/EX, EX/MEM and MEM/WB pipeline registers. It detects load-use hazards and resolves branches in the MEM stage. It also runs the variable-latency data-memory handshake, with a timeout and stall/flush performance counters. It sits beside the pipeline registers and drives their enable and flush inputs.

## Interface
Parameters:
- MAX_WAIT, 16: maximum consecutive memory wait cycles before fault.
- CNT_W, 16: performance counter width.

Ports:
- clk  in  1  clock, rising edge.
- rst  in  1  asynchronous, active-high reset.
- id_rs  in  5  rs of the instruction in ID.
- id_rt  in  5  rt of the instruction in ID.
- id_uses_rt  in  1  ID instruction reads rt as a source.
- idex_mem_read  in  1  instruction in EX is a load.
- idex_rt  in  5  load destination in EX.
- exmem_branch  in  1  Branch bit latched in EX/MEM.
- exmem_eq_ne  in  1  0 = beq, 1 = bne.
- exmem_eq  in  1  equal flag latched in EX/MEM.
- exmem_ne  in  1  not-equal flag latched in EX/MEM.
- exmem_mem_read  in  1  MEMRead latched in EX/MEM.
- exmem_mem_write  in  1  MEMWrite latched in EX/MEM.
- dmem_ack  in  1  data memory completes the access this cycle.
- pc_write  out  1  PC load enable.
- ifid_write  out  1  IF/ID load enable.
- pipe_hold  out  1  freeze ID/EX, EX/MEM and MEM/WB.
- ifid_flush  out  1  zero IF/ID on the next edge.
- idex_flush  out  1  zero ID/EX on the next edge.
- exmem_flush  out  1  zero EX/MEM on the next edge.
- pc_src  out  1  select the branch target PC.
- dmem_req  out  1  data memory access request.
- mem_timeout  out  1  sticky fault flag.
- stall_count  out  CNT_W  saturating count of stall cycles.
- flush_count  out  CNT_W  saturating count of taken branches.

## Operation
- States:
  - RUN: normal operation.
  - MEM_WAIT: waiting for dmem_ack.
  - FAULT: timeout reached; absorbing until rst.
- Definitions:
  - mem_op = exmem_mem_read | exmem_mem_write.
  - taken = exmem_branch & (exmem_eq_ne ? exmem_ne : exmem_eq).
  - lu = idex_mem_read & (idex_rt != 0) & ((idex_rt == id_rs) | (id_uses_rt & (idex_rt == id_rt))).
- dmem_req = mem_op in RUN and MEM_WAIT; 0 in FAULT.
- Controls apply in priority order: FAULT > memory hold > taken > lu > normal.
  - Memory hold (mem_op & ~dmem_ack in RUN or MEM_WAIT): pc_write=0, ifid_write=0, pipe_hold=1, all flushes 0, pc_src=0.
  - taken: pc_write=1, pc_src=1, ifid_flush=idex_flush=exmem_flush=1, ifid_write=1. Suppresses lu.
  - lu: pc_write=0, ifid_write=0, idex_flush=1 (one bubble), pipe_hold=0.
  - Normal: pc_write=1, ifid_write=1, all others 0.
  - FAULT: pc_write=0, ifid_write=0, pipe_hold=1, flushes 0, mem_timeout=1.
- Transitions:
  - RUN to MEM_WAIT when mem_op & ~dmem_ack.
  - MEM_WAIT to RUN on dmem_ack; the pipeline advances in the ack cycle.
  - MEM_WAIT to FAULT when wait_cnt reaches MAX_WAIT-1 and ~dmem_ack.
  - FAULT left only by rst.
- wait_cnt:
  - Cleared in RUN.
  - Increments each MEM_WAIT cycle without ack.
  - Width is clog2(MAX_WAIT)+1.
- stall_count: +1 on each edge where pc_write=0 outside FAULT; saturates at all-ones.
- flush_count: +1 on each edge where taken is asserted and there is no memory hold; saturates.

## Timing
- All controls are combinational from the current state and inputs (Mealy), so control latency is 0 cycles. State and counters update on the rising edge.
- While rst is high, regardless of clk:
  - state=RUN, wait_cnt=0, counters=0, mem_timeout=0.
  - All control outputs are forced to 0: pc_write, ifid_write, pipe_hold, flushes, pc_src, dmem_req.
- Reset asserted mid-wait or in FAULT aborts immediately. The first edge after rst deasserts runs in RUN.
- Zero-wait access (dmem_ack in the same cycle as mem_op) causes no stall and no state change.
- A load-use bubble lasts exactly 1 cycle. The next cycle sees the load in MEM, so lu deasserts.
- A memory hold and lu in the same cycle: the hold wins. lu is re-evaluated after release.
- dmem_ack asserted in RUN without mem_op is ignored.

## Structure
- The shared package `pipe_ctl_pkg` holds:
  - state enum {RUN, MEM_WAIT, FAULT}, 2-bit.
  - default MAX_WAIT and CNT_W constants.
- The sub-module `sat_counter` (width parameter, inc, clear, async rst) is instantiated twice: stall_count and flush_count.

## Test plan
- Load-use: lw $8 in EX (idex_mem_read=1, idex_rt=8) with id_rs=8 -> pc_write=0, ifid_write=0, idex_flush=1 for 1 cycle; stall_count=1. The same with idex_rt=0 -> no stall.
- Branch taken: exmem_branch=1, eq_ne=0, eq=1 -> pc_src=1 and three flushes for 1 cycle; flush_count=1. With eq_ne=1, ne=0 -> no flush.
- Memory wait: mem_op=1 with dmem_ack low for 3 cycles, then high -> pipe_hold=1 for 3 cycles and released in the ack cycle; stall_count=3.
- Timeout: MAX_WAIT=4, dmem_ack held low -> FAULT entered after 4 wait cycles; mem_timeout=1 and sticky; rst clears it.
- Simultaneous events: taken together with lu -> taken behaviour, no stall. Memory hold together with lu -> hold only.
- Saturation: CNT_W=4 with 20 stall cycles -> stall_count=15. Async rst mid-MEM_WAIT -> outputs zero immediately.

Source files
------------

// File: rtl/pipe_ctl_pkg.sv
// Shared constants and types for the 5-stage pipeline hazard/sequencing controller.
package pipe_ctl_pkg;

  localparam int unsigned DEF_MAX_WAIT = 16;
  localparam int unsigned DEF_CNT_W    = 16;
  localparam int unsigned STATE_W      = 2;

  localparam logic [STATE_W-1:0] RUN      = 2'd0;
  localparam logic [STATE_W-1:0] MEM_WAIT = 2'd1;
  localparam logic [STATE_W-1:0] FAULT    = 2'd2;

  // Control bundle driven to the PC and pipeline registers
  typedef struct packed {
    logic pc_write;
    logic ifid_write;
    logic pipe_hold;
    logic ifid_flush;
    logic idex_flush;
    logic exmem_flush;
    logic pc_src;
    logic dmem_req;
  } pipe_ctl_t;

endpackage

// File: rtl/sat_counter.sv
// Saturating up-counter with synchronous clear and asynchronous active-high reset.
module sat_counter #(
  parameter int unsigned W = 16
) (
  input  logic         clk,
  input  logic         rst,
  input  logic         inc,
  input  logic         clear,
  output logic [W-1:0] count
);

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      count <= '0;
    end else if (clear) begin
      count <= '0;
    end else if (inc && (count != {W{1'b1}})) begin
      count <= count + W'(1);
    end
  end

endmodule

// File: rtl/pipe_hazard_ctl.sv
// Hazard controller: load-use stalls, MEM-stage branch flushes, data-memory
// wait handshake with timeout, and stall/flush performance counters.
module pipe_hazard_ctl
  import pipe_ctl_pkg::*;
#(
  parameter int unsigned MAX_WAIT = DEF_MAX_WAIT,
  parameter int unsigned CNT_W    = DEF_CNT_W
) (
  input  logic             clk,
  input  logic             rst,
  input  logic [4:0]       id_rs,
  input  logic [4:0]       id_rt,
  input  logic             id_uses_rt,
  input  logic             idex_mem_read,
  input  logic [4:0]       idex_rt,
  input  logic             exmem_branch,
  input  logic             exmem_eq_ne,
  input  logic             exmem_eq,
  input  logic             exmem_ne,
  input  logic             exmem_mem_read,
  input  logic             exmem_mem_write,
  input  logic             dmem_ack,
  output logic             pc_write,
  output logic             ifid_write,
  output logic             pipe_hold,
  output logic             ifid_flush,
  output logic             idex_flush,
  output logic             exmem_flush,
  output logic             pc_src,
  output logic             dmem_req,
  output logic             mem_timeout,
  output logic [CNT_W-1:0] stall_count,
  output logic [CNT_W-1:0] flush_count
);

  localparam int unsigned WAIT_W = $clog2(MAX_WAIT) + 1;
  localparam logic [WAIT_W-1:0] WAIT_LAST = WAIT_W'(MAX_WAIT - 1);

  logic [STATE_W-1:0] state, state_nxt;
  logic [WAIT_W-1:0]  wait_cnt, wait_nxt;
  pipe_ctl_t          ctl;
  logic               mem_op, taken, lu, active, mem_hold;
  logic               stall_inc, flush_inc;

  assign mem_op   = exmem_mem_read | exmem_mem_write;
  assign taken    = exmem_branch & (exmem_eq_ne ? exmem_ne : exmem_eq);
  assign lu       = idex_mem_read & (idex_rt != 5'd0) &
                    ((idex_rt == id_rs) | (id_uses_rt & (idex_rt == id_rt)));
  assign active   = ~rst & ((state == RUN) | (state == MEM_WAIT));
  assign mem_hold = active & mem_op & ~dmem_ack;

  always_ff @(posedge clk or posedge rst) begin
    if (rst) begin
      state    <= RUN;
      wait_cnt <= '0;
    end else begin
      state    <= state_nxt;
      wait_cnt <= wait_nxt;
    end
  end

  // Next state and Mealy controls; reset forces every control low
  always_comb begin
    ctl       = '0;
    state_nxt = state;
    wait_nxt  = wait_cnt;
    if (!rst) begin
      unique case (state)
        RUN, MEM_WAIT: begin
          ctl.dmem_req = mem_op;
          if (mem_hold) begin
            ctl.pipe_hold = 1'b1;
          end else if (taken) begin
            ctl.pc_write    = 1'b1;
            ctl.ifid_write  = 1'b1;
            ctl.pc_src      = 1'b1;
            ctl.ifid_flush  = 1'b1;
            ctl.idex_flush  = 1'b1;
            ctl.exmem_flush = 1'b1;
          end else if (lu) begin
            ctl.idex_flush = 1'b1;
          end else begin
            ctl.pc_write   = 1'b1;
            ctl.ifid_write = 1'b1;
          end

          if (state == RUN) begin
            wait_nxt = '0;
            if (mem_hold) state_nxt = MEM_WAIT;
          end else if (dmem_ack) begin
            state_nxt = RUN;
            wait_nxt  = '0;
          end else if (wait_cnt == WAIT_LAST) begin
            state_nxt = FAULT;
          end else begin
            wait_nxt = wait_cnt + WAIT_W'(1);
          end
        end
        FAULT: begin
          ctl.pipe_hold = 1'b1;
        end
        default: begin
          state_nxt = RUN;
          wait_nxt  = '0;
        end
      endcase
    end
  end

  assign pc_write    = ctl.pc_write;
  assign ifid_write  = ctl.ifid_write;
  assign pipe_hold   = ctl.pipe_hold;
  assign ifid_flush  = ctl.ifid_flush;
  assign idex_flush  = ctl.idex_flush;
  assign exmem_flush = ctl.exmem_flush;
  assign pc_src      = ctl.pc_src;
  assign dmem_req    = ctl.dmem_req;
  assign mem_timeout = ~rst & (state == FAULT);

  assign stall_inc = active & ~ctl.pc_write;
  assign flush_inc = active & taken & ~mem_hold;

  sat_counter #(.W(CNT_W)) u_stall_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (stall_inc),
    .clear (1'b0),
    .count (stall_count)
  );

  sat_counter #(.W(CNT_W)) u_flush_cnt (
    .clk   (clk),
    .rst   (rst),
    .inc   (flush_inc),
    .clear (1'b0),
    .count (flush_count)
  );

endmodule
